// File: rtl/pixel_layer_arbiter.sv
// Per-pixel layer compositor for the palette LUT: fixed-priority layer pick with transparency,
// plus a frame-aligned blinking "player hit" recolor of one layer. Two-stage pipeline, no stall.
module pixel_layer_arbiter #(
    parameter int              NUM_LAYERS     = 4,
    parameter int              ID_W           = 6,
    parameter logic [ID_W-1:0] TRANSPARENT_ID = 6'd63,
    parameter logic [ID_W-1:0] BG_ID          = 6'd22,
    parameter logic [ID_W-1:0] FLASH_ID       = 6'd24,
    parameter int              FLASH_LAYER    = 2,
    parameter int              FLASH_FRAMES   = 30,
    parameter int              BLINK_PERIOD   = 4,
    localparam int             WL_W           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       frame_start_i,
    input  logic                       pix_valid_i,
    input  logic [NUM_LAYERS*ID_W-1:0] layer_id_i,
    input  logic [NUM_LAYERS-1:0]      layer_en_i,
    input  logic                       hit_i,
    output logic                       out_valid_o,
    output logic [ID_W-1:0]            color_id_o,
    output logic [WL_W-1:0]            win_layer_o,
    output logic                       flash_active_o
);

    localparam int         CNT_BIT  = $clog2(BLINK_PERIOD);
    localparam logic [7:0] LAST_CNT = 8'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FLASH_ON, FLASH_OFF} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d, cnt_inc;
    logic                       pending_q, pending_d;
    logic                       flash_active_q;
    logic                       flash_on;

    logic                       s1_valid_q;
    logic [NUM_LAYERS*ID_W-1:0] s1_id_q;
    logic [NUM_LAYERS-1:0]      s1_en_q;
    logic                       out_valid_q;
    logic [ID_W-1:0]            color_q;
    logic [WL_W-1:0]            win_q;

    logic [NUM_LAYERS-1:0]      opaque;
    logic                       win_found;
    logic [WL_W-1:0]            win_idx;
    logic [ID_W-1:0]            win_id;
    logic [ID_W-1:0]            s2_color;
    logic [WL_W-1:0]            s2_win;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
            assign opaque[gi] = s1_en_q[gi] && (s1_id_q[gi*ID_W +: ID_W] != TRANSPARENT_ID);
        end
    endgenerate

    // Ascending scan so the last opaque layer seen (highest index) wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (opaque[k]) begin
                win_found = 1'b1;
                win_idx   = WL_W'(k);
                win_id    = s1_id_q[k*ID_W +: ID_W];
            end
        end
    end

    always_comb begin
        s2_color = BG_ID;
        s2_win   = '0;
        if (win_found) begin
            s2_win   = win_idx;
            s2_color = (flash_on && (win_idx == WL_W'(FLASH_LAYER))) ? FLASH_ID : win_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_en_q     <= '0;
            out_valid_q <= 1'b0;
            color_q     <= '0;
            win_q       <= '0;
        end else begin
            s1_valid_q  <= pix_valid_i;
            if (pix_valid_i) begin
                s1_id_q <= layer_id_i;
                s1_en_q <= layer_en_i;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                color_q <= s2_color;
                win_q   <= s2_win;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            flash_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            flash_active_q <= (state_d == FLASH_ON) || (state_d == FLASH_OFF);
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    // State only moves on frame_start (except IDLE->ARMED), so the blink never tears mid-frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | hit_i;
        unique case (state_q)
            IDLE, ARMED: begin
                if (frame_start_i && (pending_q || hit_i)) begin
                    state_d   = FLASH_ON;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else if (hit_i) begin
                    state_d = ARMED;
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (frame_start_i) begin
                    if (pending_q || hit_i) begin
                        state_d   = FLASH_ON;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = cnt_inc[CNT_BIT] ? FLASH_OFF : FLASH_ON;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flash_on = (state_q == FLASH_ON);
    end

    assign out_valid_o    = out_valid_q;
    assign color_id_o     = color_q;
    assign win_layer_o    = win_q;
    assign flash_active_o = flash_active_q;

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Randomized bench for pixel_layer_arbiter against a frame-level behavioural model of
// layer priority and the hit-flash schedule, plus directed priority/flash/reset cases.
module tb_pixel_layer_arbiter;

    localparam int NL = 4;
    localparam int IW = 6;
    localparam int LW = 2;
    localparam int FLASH_FRAMES = 30;
    localparam int BLINK = 4;
    localparam int FRAME_LEN = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              frame_start_i = 1'b0;
    logic              pix_valid_i = 1'b0;
    logic [NL*IW-1:0]  layer_id_i = '0;
    logic [NL-1:0]     layer_en_i = '0;
    logic              hit_i = 1'b0;
    logic              out_valid_o;
    logic [IW-1:0]     color_id_o;
    logic [LW-1:0]     win_layer_o;
    logic              flash_active_o;

    int checks = 0;
    int failures = 0;

    // Model state: pixel waiting in the first stage, last output, flash schedule in frames.
    logic              m_s1_valid;
    logic [NL*IW-1:0]  m_s1_ids;
    logic [NL-1:0]     m_s1_en;
    logic              m_valid;
    int                m_color;
    int                m_win;
    bit                m_running;
    int                m_frame;
    bit                m_pending;

    logic [NL*IW-1:0]  player_px;

    pixel_layer_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .frame_start_i  (frame_start_i),
        .pix_valid_i    (pix_valid_i),
        .layer_id_i     (layer_id_i),
        .layer_en_i     (layer_en_i),
        .hit_i          (hit_i),
        .out_valid_o    (out_valid_o),
        .color_id_o     (color_id_o),
        .win_layer_o    (win_layer_o),
        .flash_active_o (flash_active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1_valid = 1'b0;
        m_s1_ids   = '0;
        m_s1_en    = '0;
        m_valid    = 1'b0;
        m_color    = 0;
        m_win      = 0;
        m_running  = 0;
        m_frame    = 0;
        m_pending  = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic fs, input logic pv, input logic [NL*IW-1:0] ids,
                              input logic [NL-1:0] en, input logic ht);
        bit red;
        bit found;
        int w;
        int id;
        red = m_running && (((m_frame / BLINK) % 2) == 0);
        m_valid = m_s1_valid;
        if (m_s1_valid) begin
            found = 0;
            w = 0;
            id = 0;
            for (int k = NL - 1; k >= 0; k--) begin
                if (!found && m_s1_en[k] && (m_s1_ids[k*IW +: IW] != 6'd63)) begin
                    found = 1;
                    w = k;
                    id = int'(m_s1_ids[k*IW +: IW]);
                end
            end
            if (!found) begin
                m_color = 22;
                m_win   = 0;
            end else begin
                m_color = (red && w == 2) ? 24 : id;
                m_win   = w;
            end
        end
        m_s1_valid = pv;
        if (pv) begin
            m_s1_ids = ids;
            m_s1_en  = en;
        end
        if (fs) begin
            if (m_pending || ht) begin
                m_running = 1;
                m_frame   = 0;
                m_pending = 0;
            end else if (m_running) begin
                m_frame++;
                if (m_frame == FLASH_FRAMES) begin
                    m_running = 0;
                    m_frame   = 0;
                end
            end
        end else if (ht) begin
            m_pending = 1;
        end
    endtask

    task automatic step(input logic fs, input logic pv, input logic [NL*IW-1:0] ids,
                        input logic [NL-1:0] en, input logic ht);
        frame_start_i = fs;
        pix_valid_i   = pv;
        layer_id_i    = ids;
        layer_en_i    = en;
        hit_i         = ht;
        @(posedge clk_i);
        model_edge(fs, pv, ids, en, ht);
        #1;
        check("out_valid", 32'(out_valid_o), 32'(m_valid));
        check("color_id", 32'(color_id_o), 32'(m_color));
        check("win_layer", 32'(win_layer_o), 32'(m_win));
        check("flash_active", 32'(flash_active_o), 32'(m_running));
    endtask

    initial begin
        logic [NL*IW-1:0] rids;
        logic [NL*IW-1:0] all_tr;
        int exp_c;
        player_px = {6'd63, 6'd5, 6'd9, 6'd22};
        all_tr    = {6'd63, 6'd63, 6'd63, 6'd63};
        model_reset();

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_color", 32'(color_id_o), 32'd0);
        check("rst_active", 32'(flash_active_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #4;

        // Priority, masked priority, fallback, back-to-back
        step(0, 1, player_px, 4'b1111, 0);
        step(0, 1, player_px, 4'b1011, 0);
        check("prio_color", 32'(color_id_o), 32'd5);
        check("prio_win", 32'(win_layer_o), 32'd2);
        step(0, 1, all_tr, 4'b1111, 0);
        check("mask_color", 32'(color_id_o), 32'd9);
        check("mask_win", 32'(win_layer_o), 32'd1);
        step(0, 1, player_px, 4'b0000, 0);
        check("trans_color", 32'(color_id_o), 32'd22);
        check("trans_win", 32'(win_layer_o), 32'd0);
        step(0, 0, '0, '0, 0);
        check("dis_color", 32'(color_id_o), 32'd22);
        step(0, 0, '0, '0, 0);
        check("hold_valid", 32'(out_valid_o), 32'd0);
        check("hold_color", 32'(color_id_o), 32'd22);

        // Flash: hit, frame_start 10 cycles later, player pixel each cycle
        step(0, 1, player_px, 4'b1111, 1);
        for (int i = 0; i < 9; i++) step(0, 1, player_px, 4'b1111, 0);
        for (int f = 0; f < 33; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                step(c == 0, 1, player_px, 4'b1111, 0);
                if (c == 0) check("flash_len", 32'(flash_active_o), 32'(f < FLASH_FRAMES));
                if (c == 3) begin
                    exp_c = (f < FLASH_FRAMES && ((f / BLINK) % 2) == 0) ? 24 : 5;
                    check("flash_blink", 32'(color_id_o), 32'(exp_c));
                end
            end
        end

        // Same-cycle hit+frame_start from IDLE, then retrigger during frame 20
        for (int g = 0; g < 54; g++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                step(c == 0, 1, player_px, 4'b1111, (g == 0 && c == 0) || (g == 20 && c == 4));
                if (c == 0) check("retrig_len", 32'(flash_active_o), 32'(g < 51));
                if (g == 0 && c == 3) check("same_cycle_red", 32'(color_id_o), 32'd24);
            end
        end

        // Asynchronous reset mid-flash with pixels streaming
        step(1, 1, player_px, 4'b1111, 1);
        for (int i = 0; i < 5; i++) step(0, 1, player_px, 4'b1111, 0);
        rst_i = 1'b1;
        #1;
        check("async_valid", 32'(out_valid_o), 32'd0);
        check("async_color", 32'(color_id_o), 32'd0);
        check("async_active", 32'(flash_active_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        model_reset();
        step(0, 1, player_px, 4'b1111, 0);
        check("post_rst_lat1", 32'(out_valid_o), 32'd0);
        step(0, 1, player_px, 4'b1111, 0);
        check("post_rst_lat2", 32'(out_valid_o), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 3) == 0) rids[k*IW +: IW] = 6'd63;
                else rids[k*IW +: IW] = 6'($urandom_range(0, 62));
            end
            step((i % 12) == 0, $urandom_range(0, 3) != 0, rids, 4'($urandom),
                 $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
